imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate-generation stage for the decode pipeline. It decodes the instruction format from the opcode itself rather than taking per-type flags. It produces the fully shifted, XLEN-sign-extended immediate, a format code and an illegal-opcode flag. Results pass through a 2-entry skid buffer with valid/ready handshakes so that decode can stall independently of fetch. The stage sits between the IF/ID register and the register-read/execute mux, and replaces the combinational immediate generator.

## Interface
- `XLEN`, default 32: datapath width. Legal values are 32 and 64; any other value is an elaboration error.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: upstream holds a valid instruction.
- `in_ready` output, 1 bit: the stage can accept an instruction. Driven from a register.
- `in_inst` input, 32 bits: raw instruction word.
- `in_pc` input, XLEN bits: PC of the instruction. Passed through unchanged.
- `flush` input, 1 bit: synchronous kill of all buffered entries.
- `out_valid` output, 1 bit: the head entry is valid.
- `out_ready` input, 1 bit: downstream accepts the head entry.
- `out_imm` output, XLEN bits: final immediate.
- `out_fmt` output, 3 bits: format code, type `fmt_e`.
- `out_pc` output, XLEN bits: PC of the head entry.
- `out_illegal` output, 1 bit: the opcode is unsupported.

## Operation
- **Decode by `inst[6:0]`:**
  - 0010011, 0000011, 1100111 → `FMT_I`.
  - 0011011 → `FMT_I`, only when XLEN=64. It is illegal when XLEN=32.
  - 0100011 → `FMT_S`.
  - 1100011 → `FMT_B`.
  - 0110111, 0010111 → `FMT_U`.
  - 1101111 → `FMT_J`.
  - 0110011, plus 0111011 when XLEN=64 → `FMT_R`, imm 0.
  - Anything else → `FMT_NONE`, imm 0, `out_illegal`=1.
- **I format:** `inst[31:20]` sign-extended to XLEN.
- **Shift-immediate exception:** when opcode=0010011 and funct3 is 001 or 101, the immediate is the zero-extended shamt instead. The shamt is `inst[24:20]` when XLEN=32 and `inst[25:20]` when XLEN=64. For opcode 0011011 it is always `inst[24:20]`.
- **S format:** `{inst[31:25], inst[11:7]}`, sign-extended.
- **B format:** `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}` (13 bits), sign-extended. The LSB shift is applied here; downstream must not shift again.
- **J format:** `{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}` (21 bits), sign-extended.
- **U format:** `{inst[31:12], 12'b0}`. When XLEN=64 this is sign-extended from bit 31.
- **Skid buffer:** two entries, each holding {imm, fmt, pc, illegal}. The buffer state is `count` ∈ {EMPTY, ONE, TWO}.
  - Enqueue happens when `in_valid && in_ready`. Dequeue happens when `out_valid && out_ready`.
  - EMPTY + enq → ONE.
  - ONE + enq without deq → TWO.
  - ONE + deq without enq → EMPTY.
  - ONE + enq + deq → ONE.
  - TWO + deq → ONE. No enqueue is possible in TWO because `in_ready`=0.
  - `in_ready` is registered and equals (next count ≠ TWO).
  - `out_valid` = (count ≠ EMPTY).
  - Strict FIFO order. The head entry is stable while `out_valid && !out_ready`.
- **Flush:** has priority over everything. Next state is EMPTY, and any `in_valid` in the flush cycle is dropped. `in_ready`=1 the next cycle.
- **Reset:** count=EMPTY, `in_ready`=1, `out_valid`=0, `out_imm`=0, `out_fmt`=`FMT_NONE`, `out_pc`=0, `out_illegal`=0. Reset mid-operation discards all entries immediately.
- **Empty buffer:** payload outputs are 0 / `FMT_NONE` whenever `out_valid`=0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `out_*` after edge N with `out_valid`=1.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- `in_ready` falls the cycle after the second buffered entry is written. No combinational path exists from `out_ready` to `in_ready`.
- Decode logic is combinational before the buffer write. Outputs are driven directly from buffer registers.

## Structure
- `imm_pkg`: `fmt_e` (`FMT_NONE`=0, `FMT_R`, `FMT_I`, `FMT_S`, `FMT_B`, `FMT_U`, `FMT_J`), opcode localparams, and an entry struct parametrised via XLEN-sized fields in the top level.
- Sub-module `imm_decode`: purely combinational, XLEN-parametrised. It maps inst → {imm, fmt, illegal}. The top level owns the skid buffer and the handshake.

## Test plan
- **Basic decode, XLEN=32, `out_ready`=1:** stream 0xFFF00093, 0xFE20AE23, 0xFE000CE3, 0x001000EF, 0xABCDE2B7 on consecutive cycles → one per cycle at latency 1:
  - 0xFFFFFFFF / `FMT_I`
  - 0xFFFFFFFC / `FMT_S`
  - 0xFFFFFFF8 / `FMT_B`
  - 0x00000800 / `FMT_J`
  - 0xABCDE000 / `FMT_U`
- **XLEN=64:** 0x02109093 (slli by 33) → imm 0x21, `FMT_I`. 0xABCDE2B7 → 0xFFFFFFFFABCDE000.
- **Illegal:** 0x0000007F → `out_illegal`=1, `FMT_NONE`, imm 0. 0x0000001B with XLEN=32 → illegal.
- **Backpressure:** hold `out_ready`=0 and present A, B, C → A and B accepted, `in_ready`=0 from the cycle after B, C held upstream, head stays A. Release `out_ready` → A, B, C emerge in order with no loss or duplication.
- **Flush:** with TWO entries, pulse `flush` while `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1, and the flush-cycle instruction never appears.
- **Async reset:** assert `rst` mid-stream between edges → outputs go to their reset values immediately. After release, the first accepted instruction emerges correctly.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
package imm_pkg;

    // Format code reported with every decoded instruction.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_TWO   = 2'd2
    } count_e;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode-driven immediate decoder: inst -> {imm, fmt, illegal}.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

    // Every candidate immediate is sign-extended from its own top bit; the
    // B and J forms already carry the implicit zero LSB.
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // Select format and immediate from the opcode; unknown opcodes flag illegal.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                fmt = FMT_I;
                if (is_shift) begin
                    // shamt is 6 bits wide on RV64, 5 bits on RV32
                    if (XLEN == 64) imm[5:0] = inst[25:20];
                    else            imm[4:0] = inst[24:20];
                end else begin
                    imm = imm_i;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = imm_i;
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    fmt = FMT_I;
                    // word shifts only ever use a 5-bit shamt
                    if (is_shift) imm[4:0] = inst[24:20];
                    else          imm      = imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = imm_s;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = imm_u;
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = imm_j;
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            OPC_OP32: begin
                if (XLEN == 64) fmt = FMT_R;
                else            illegal = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode feeds a two-entry skid
// buffer with valid/ready on both sides and a registered in_ready.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    entry_t          dec_entry;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    count_e count_q, count_d;
    entry_t head_q, head_d;   // oldest entry, drives out_*
    entry_t tail_q, tail_d;   // second entry, only live in CNT_TWO
    logic   in_ready_q;
    logic   enq, deq;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, pc: in_pc, illegal: dec_illegal};

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != CNT_EMPTY);
    assign enq       = in_valid && in_ready_q;
    assign deq       = out_valid && out_ready;

    // Next-state and slot updates. Slots are zeroed whenever they fall out of
    // use so the payload outputs read 0 / FMT_NONE while out_valid is low.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = CNT_EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (enq) begin
                        head_d  = dec_entry;
                        count_d = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (enq && deq) begin
                        head_d = dec_entry;
                    end else if (enq) begin
                        tail_d  = dec_entry;
                        count_d = CNT_TWO;
                    end else if (deq) begin
                        head_d  = '0;
                        count_d = CNT_EMPTY;
                    end
                end
                CNT_TWO: begin
                    // in_ready is low here, so only a dequeue can occur
                    if (deq) begin
                        head_d  = tail_q;
                        tail_d  = '0;
                        count_d = CNT_ONE;
                    end
                end
                default: begin
                    count_d = CNT_EMPTY;
                    head_d  = '0;
                    tail_d  = '0;
                end
            endcase
        end
    end

    // State registers; in_ready is precomputed from the next count so there is
    // no combinational path from out_ready to in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= CNT_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (count_d != CNT_TWO);
        end
    end

    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_pc      = head_q.pc;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 and XLEN=64 instances.
module tb_imm_gen_stage;
    import imm_pkg::*;

    logic        clk, rst;
    // XLEN=32 instance
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_pc, out_imm, out_pc;
    logic [2:0]  out_fmt;
    // XLEN=64 instance
    logic        in_valid_w, in_ready_w, flush_w, out_valid_w, out_ready_w, out_illegal_w;
    logic [31:0] in_inst_w;
    logic [63:0] in_pc_w, out_imm_w, out_pc_w;
    logic [2:0]  out_fmt_w;

    int errors = 0;
    int checks = 0;

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_inst(in_inst_w), .in_pc(in_pc_w), .flush(flush_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .out_imm(out_imm_w), .out_fmt(out_fmt_w),
        .out_pc(out_pc_w), .out_illegal(out_illegal_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; in_inst = '0; in_pc = '0; flush = 0; out_ready = 1;
        in_valid_w = 0; in_inst_w = '0; in_pc_w = '0; flush_w = 0; out_ready_w = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_imm",       out_imm, 0);
        chk("rst_fmt",       out_fmt, FMT_NONE);
        chk("rst_pc",        out_pc, 0);
        chk("rst_illegal",   out_illegal, 0);
        step();
        rst = 1'b0;
        step();

        // ---- basic decode stream, XLEN=32, one per cycle ----
        in_valid = 1; in_inst = 32'hFFF00093; in_pc = 32'h100;
        step();
        chk("i_valid", out_valid, 1);
        chk("i_imm", out_imm, 32'hFFFFFFFF);
        chk("i_fmt", out_fmt, FMT_I);
        chk("i_pc",  out_pc, 32'h100);
        in_inst = 32'hFE20AE23; in_pc = 32'h104;
        step();
        chk("s_imm", out_imm, 32'hFFFFFFFC);
        chk("s_fmt", out_fmt, FMT_S);
        chk("s_pc",  out_pc, 32'h104);
        in_inst = 32'hFE000CE3; in_pc = 32'h108;
        step();
        chk("b_imm", out_imm, 32'hFFFFFFF8);
        chk("b_fmt", out_fmt, FMT_B);
        in_inst = 32'h001000EF; in_pc = 32'h10C;
        step();
        chk("j_imm", out_imm, 32'h00000800);
        chk("j_fmt", out_fmt, FMT_J);
        in_inst = 32'hABCDE2B7; in_pc = 32'h110;
        step();
        chk("u_imm", out_imm, 32'hABCDE000);
        chk("u_fmt", out_fmt, FMT_U);
        chk("u_valid", out_valid, 1);
        in_inst = 32'h02109093; in_pc = 32'h114;   // slli by 1 on RV32
        step();
        chk("shamt32_imm", out_imm, 32'h1);
        chk("shamt32_fmt", out_fmt, FMT_I);
        in_inst = 32'h00000033;                     // add: R format
        step();
        chk("r_imm", out_imm, 0);
        chk("r_fmt", out_fmt, FMT_R);
        chk("r_illegal", out_illegal, 0);
        in_inst = 32'h0000007F;                     // unsupported opcode
        step();
        chk("ill_flag", out_illegal, 1);
        chk("ill_fmt", out_fmt, FMT_NONE);
        chk("ill_imm", out_imm, 0);
        in_inst = 32'h0000001B;                     // OP-IMM-32 on RV32
        step();
        chk("ill32_flag", out_illegal, 1);
        chk("ill32_fmt", out_fmt, FMT_NONE);
        in_valid = 0;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_imm", out_imm, 0);
        chk("drain_fmt", out_fmt, FMT_NONE);
        chk("drain_illegal", out_illegal, 0);

        // ---- XLEN=64 decode ----
        in_valid_w = 1; in_inst_w = 32'h02109093; in_pc_w = 64'h1_0000_0000;
        step();
        chk("w_shamt_imm", out_imm_w, 64'h21);
        chk("w_shamt_fmt", out_fmt_w, FMT_I);
        chk("w_pc", out_pc_w, 64'h1_0000_0000);
        in_inst_w = 32'hABCDE2B7;
        step();
        chk("w_u_imm", out_imm_w, 64'hFFFFFFFFABCDE000);
        chk("w_u_fmt", out_fmt_w, FMT_U);
        in_inst_w = 32'h0000001B;                   // addiw x0,x0,0
        step();
        chk("w_iw_fmt", out_fmt_w, FMT_I);
        chk("w_iw_illegal", out_illegal_w, 0);
        in_inst_w = 32'hFFF00093;
        step();
        chk("w_i_imm", out_imm_w, 64'hFFFFFFFFFFFFFFFF);
        in_valid_w = 0;
        step();
        chk("w_drain_valid", out_valid_w, 0);

        // ---- backpressure: A, B accepted, C held ----
        out_ready = 0;
        in_valid = 1; in_inst = 32'h00100093; in_pc = 32'hA0;    // A: imm 1
        step();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_imm", out_imm, 1);
        chk("bp_a_ready", in_ready, 1);
        in_inst = 32'h00200093; in_pc = 32'hB0;                  // B: imm 2
        step();
        chk("bp_b_ready", in_ready, 0);
        chk("bp_b_head", out_imm, 1);
        in_inst = 32'h00300093; in_pc = 32'hC0;                  // C: imm 3
        step();
        chk("bp_c_ready", in_ready, 0);
        chk("bp_c_head", out_imm, 1);
        chk("bp_c_head_pc", out_pc, 32'hA0);
        step();
        chk("bp_hold_head", out_imm, 1);
        out_ready = 1;
        step();
        chk("bp_rel_b", out_imm, 2);
        chk("bp_rel_b_pc", out_pc, 32'hB0);
        chk("bp_rel_ready", in_ready, 1);
        step();                                                  // C enqueued
        chk("bp_rel_c", out_imm, 3);
        chk("bp_rel_c_pc", out_pc, 32'hC0);
        in_valid = 0;
        step();
        chk("bp_end_valid", out_valid, 0);

        // ---- flush with two entries and in_valid high ----
        out_ready = 0;
        in_valid = 1; in_inst = 32'h00400093; in_pc = 32'hD0;
        step();
        in_inst = 32'h00500093;
        step();
        chk("fl_two_ready", in_ready, 0);
        in_inst = 32'h00700093; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_imm", out_imm, 0);
        out_ready = 1;
        step();
        chk("fl_gone", out_valid, 0);

        // flush in ONE with an acceptable enqueue: that enqueue is dropped
        out_ready = 0;
        in_valid = 1; in_inst = 32'h00800093;
        step();
        in_inst = 32'h00900093; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("fl1_valid", out_valid, 0);
        chk("fl1_ready", in_ready, 1);
        out_ready = 1;
        step();
        chk("fl1_gone", out_valid, 0);

        // ---- asynchronous reset mid-operation ----
        out_ready = 0; out_ready_w = 0;
        in_valid = 1; in_inst = 32'h00A00093; in_pc = 32'hE0;
        in_valid_w = 1; in_inst_w = 32'h00A00093;
        step();
        chk("ar_pre_valid", out_valid, 1);
        in_valid = 0; in_valid_w = 0;
        #3 rst = 1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_imm", out_imm, 0);
        chk("ar_pc", out_pc, 0);
        chk("ar_w_valid", out_valid_w, 0);
        #2 rst = 0;
        out_ready = 1; out_ready_w = 1;
        in_valid = 1; in_inst = 32'hFE20AE23; in_pc = 32'hF0;
        step();
        chk("ar_post_valid", out_valid, 1);
        chk("ar_post_imm", out_imm, 32'hFFFFFFFC);
        chk("ar_post_fmt", out_fmt, FMT_S);
        chk("ar_post_pc", out_pc, 32'hF0);
        in_valid = 0;
        step();
        chk("ar_post_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
